// File: rtl/alien_pkg.sv
// -----------------------------------------------------------------------------
// alien_pkg
// Shared types and geometry helpers for the alien formation controller and
// for the renderer / collision logic that index the same alive bitmap.
//   formation_state_t : formation controller FSM states
//   direction_t       : horizontal march direction
//   DEF_NUM_ROWS/COLS : default grid geometry
//   ROW_W / COL_W     : row / column index widths for the default grid
//   idx_w()           : index width for a count of n, never narrower than 1 bit
// -----------------------------------------------------------------------------
package alien_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MARCH   = 3'd1,
        DESCEND = 3'd2,
        CLEARED = 3'd3,
        LANDED  = 3'd4
    } formation_state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } direction_t;

    // $clog2 of a 1-entry dimension is 0, which cannot size a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_ROWS = 3;
    localparam int DEF_NUM_COLS = 5;
    localparam int ROW_W        = idx_w(DEF_NUM_ROWS);
    localparam int COL_W        = idx_w(DEF_NUM_COLS);

endpackage

// File: rtl/alien_column_scan.sv
// -----------------------------------------------------------------------------
// alien_column_scan
// Purely combinational summary of an alive bitmap (bit row*NUM_COLS+col).
//   alive       in  : alive bitmap, row 0 = top
//   seed_col    in  : preferred column for shooter selection (any value)
//   left_col    out : leftmost column with a live alien (0 if none)
//   right_col   out : rightmost column with a live alien (0 if none)
//   bottom_row  out : lowest row with a live alien (0 if none)
//   alive_count out : number of live aliens
//   armed       out : per column, only the lowest live alien
//   pick_valid  out : some column holds an armed alien
//   pick_row    out : row of the armed alien in the picked column
//   pick_col    out : first armed column at or after seed, wrapping
// -----------------------------------------------------------------------------
module alien_column_scan
    import alien_pkg::*;
#(
    parameter  int NUM_ROWS = DEF_NUM_ROWS,
    parameter  int NUM_COLS = DEF_NUM_COLS,
    localparam int R_W      = idx_w(NUM_ROWS),
    localparam int C_W      = idx_w(NUM_COLS),
    localparam int CNT_W    = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
    input  logic [NUM_ROWS*NUM_COLS-1:0] alive,
    input  logic [C_W-1:0]               seed_col,
    output logic [C_W-1:0]               left_col,
    output logic [C_W-1:0]               right_col,
    output logic [R_W-1:0]               bottom_row,
    output logic [CNT_W-1:0]             alive_count,
    output logic [NUM_ROWS*NUM_COLS-1:0] armed,
    output logic                         pick_valid,
    output logic [R_W-1:0]               pick_row,
    output logic [C_W-1:0]               pick_col
);

    logic [NUM_COLS-1:0]   col_any;
    logic [NUM_ROWS-1:0]   row_any;
    logic [R_W-1:0]        col_low [NUM_COLS];
    logic [2*NUM_COLS-1:0] rot;
    logic [C_W-1:0]        seed_mod;
    int                    pick_sum;

    always_comb begin : col_scan
        armed       = '0;
        col_any     = '0;
        row_any     = '0;
        alive_count = '0;
        left_col    = '0;
        right_col   = '0;
        bottom_row  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            col_low[c] = '0;
            // Walk bottom-up: the first live alien seen is the armed one,
            // col_any doubles as the "something live below" flag.
            for (int r = NUM_ROWS - 1; r >= 0; r--) begin
                if (alive[r*NUM_COLS+c] && !col_any[c]) begin
                    armed[r*NUM_COLS+c] = 1'b1;
                    col_low[c]          = R_W'(r);
                end
                col_any[c] = col_any[c] | alive[r*NUM_COLS+c];
            end
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                row_any[r]  = row_any[r] | alive[r*NUM_COLS+c];
                alive_count = alive_count + CNT_W'(alive[r*NUM_COLS+c]);
            end
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_any[r]) bottom_row = R_W'(r);
        end
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (col_any[c]) left_col = C_W'(c);
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_any[c]) right_col = C_W'(c);
        end
    end

    always_comb begin : shooter_pick
        // seed_col < 2*NUM_COLS always holds for a clog2-sized field, so a
        // single conditional subtract is a full modulo.
        seed_mod   = (32'(seed_col) >= 32'(NUM_COLS)) ? seed_col - C_W'(NUM_COLS) : seed_col;
        rot        = {col_any, col_any} >> seed_mod;
        pick_valid = 1'b0;
        pick_col   = '0;
        pick_row   = '0;
        pick_sum   = 0;
        // Descending so the smallest offset from the seed wins.
        for (int k = NUM_COLS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_valid = 1'b1;
                pick_sum   = int'(seed_mod) + k;
                if (pick_sum >= NUM_COLS) pick_sum = pick_sum - NUM_COLS;
                pick_col   = C_W'(pick_sum);
            end
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (pick_col == C_W'(c)) pick_row = col_low[c];
        end
    end

endmodule

// File: rtl/alien_formation_ctrl.sv
// -----------------------------------------------------------------------------
// alien_formation_ctrl
// Holds the alien grid as an origin plus alive bitmap, marches it on a step
// timer, descends/reverses at the screen edges, resolves hits and picks
// shooters.
//   clk, rst_n        : clock, asynchronous active-low reset
//   tick              : frame enable; counts toward the next move
//   start             : reload a full formation and march (highest priority)
//   hit_valid/row/col : hit report from the collision unit
//   hit_ack           : pulse, the reported hit killed a live alien
//   fire_req/seed_col : shooter request, preferred starting column
//   shooter_valid/row/col : pulse with the chosen armed alien
//   origin_x/y        : formation origin; alien = origin + (col*SX, row*SY)
//   alive_matrix      : [row][col] alive bits, bit row*NUM_COLS+col
//   armed_matrix      : lowest live alien per column
//   step_pulse        : high in the cycle the origin takes its new value
//   cleared / landed  : level flags for the game FSM
//
// Request/response handshakes: hit_valid and fire_req are single-cycle
// requests with no ready; each is sampled on the clock edge and answered by a
// one-cycle pulse (hit_ack / shooter_valid) in the following cycle, or by no
// pulse at all when the request is rejected. Requesters never wait.
// -----------------------------------------------------------------------------
module alien_formation_ctrl
    import alien_pkg::*;
#(
    parameter  int NUM_ROWS     = DEF_NUM_ROWS,
    parameter  int NUM_COLS     = DEF_NUM_COLS,
    parameter  int POS_W        = 16,
    parameter  int SPACING_X    = 64,
    parameter  int SPACING_Y    = 32,
    parameter  int START_X      = 100,
    parameter  int START_Y      = 50,
    parameter  int ALIEN_W      = 32,
    parameter  int ALIEN_H      = 16,
    parameter  int SCREEN_W     = 640,
    parameter  int LAND_Y       = 400,
    parameter  int STEP_X       = 8,
    parameter  int STEP_Y       = 16,
    parameter  int MIN_PERIOD   = 2,
    parameter  int PERIOD_SCALE = 4,
    localparam int R_W          = idx_w(NUM_ROWS),
    localparam int C_W          = idx_w(NUM_COLS),
    localparam int NUM_ALIENS   = NUM_ROWS * NUM_COLS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  hit_valid,
    input  logic [R_W-1:0]        hit_row,
    input  logic [C_W-1:0]        hit_col,
    output logic                  hit_ack,
    input  logic                  fire_req,
    input  logic [C_W-1:0]        fire_seed_col,
    output logic                  shooter_valid,
    output logic [R_W-1:0]        shooter_row,
    output logic [C_W-1:0]        shooter_col,
    output logic [POS_W-1:0]      origin_x,
    output logic [POS_W-1:0]      origin_y,
    output logic [NUM_ALIENS-1:0] alive_matrix,
    output logic [NUM_ALIENS-1:0] armed_matrix,
    output logic                  step_pulse,
    output logic                  cleared,
    output logic                  landed
);

    localparam int CNT_W      = $clog2(NUM_ALIENS + 1);
    localparam int MAX_PERIOD = MIN_PERIOD + (NUM_ALIENS - 1) * PERIOD_SCALE;
    localparam int STEP_CNT_W = $clog2(MAX_PERIOD + 1);

    formation_state_t        state;
    formation_state_t        state_next;
    direction_t              dir;
    logic [STEP_CNT_W-1:0]   step_cnt;

    logic [C_W-1:0]          left_col;
    logic [C_W-1:0]          right_col;
    logic [R_W-1:0]          bottom_row;
    logic [CNT_W-1:0]        alive_count;
    logic                    pick_valid;
    logic [R_W-1:0]          pick_row;
    logic [C_W-1:0]          pick_col;

    logic                    active;
    logic [31:0]             period;
    logic                    cnt_done;
    logic [31:0]             right_extent;
    logic [31:0]             left_extent;
    logic                    at_edge;
    logic                    move;
    logic                    descend;
    logic [POS_W-1:0]        next_y;
    logic                    lands;
    logic [NUM_ALIENS-1:0]   hit_sel;
    logic                    hit_kill;
    logic                    last_kill;
    logic                    fire_hit;

    alien_column_scan #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_scan (
        .alive       (alive_matrix),
        .seed_col    (fire_seed_col),
        .left_col    (left_col),
        .right_col   (right_col),
        .bottom_row  (bottom_row),
        .alive_count (alive_count),
        .armed       (armed_matrix),
        .pick_valid  (pick_valid),
        .pick_row    (pick_row),
        .pick_col    (pick_col)
    );

    // Move, edge and hit decode. Everything reads the registered bitmap, so a
    // hit landing in the same cycle as a move does not affect that move.
    always_comb begin
        // alive_count is never 0 while active, so the wrap in IDLE/CLEARED
        // is harmless.
        period       = 32'(MIN_PERIOD) + (32'(alive_count) - 32'd1) * 32'(PERIOD_SCALE);
        // >= so a period that just shrank below the counter fires at once.
        cnt_done     = (32'(step_cnt) + 32'd1) >= period;
        right_extent = 32'(origin_x) + 32'(right_col) * 32'(SPACING_X)
                     + 32'(ALIEN_W) + 32'(STEP_X);
        left_extent  = 32'(origin_x) + 32'(left_col) * 32'(SPACING_X);
        at_edge      = (dir == DIR_RIGHT) ? (right_extent > 32'(SCREEN_W))
                                          : (left_extent < 32'(STEP_X));
        move         = active && tick && cnt_done && !start;
        descend      = move && at_edge;
        next_y       = descend ? origin_y + POS_W'(STEP_Y) : origin_y;
        lands        = move && ((32'(next_y) + 32'(bottom_row) * 32'(SPACING_Y)
                                 + 32'(ALIEN_H)) >= 32'(LAND_Y));
        // Out-of-range coordinates select nothing and so are ignored.
        hit_sel      = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                hit_sel[r*NUM_COLS+c] = (hit_row == R_W'(r)) && (hit_col == C_W'(c));
            end
        end
        hit_kill     = active && hit_valid && !start && (|(hit_sel & alive_matrix));
        last_kill    = hit_kill && (alive_count == CNT_W'(1));
        fire_hit     = active && fire_req && pick_valid;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM: next state. Clearing beats landing when both happen together.
    always_comb begin
        state_next = state;
        if (start)                 state_next = MARCH;
        else if (last_kill)        state_next = CLEARED;
        else if (lands)            state_next = LANDED;
        else if (descend)          state_next = DESCEND;
        else if (state == DESCEND) state_next = MARCH;
    end

    // FSM: outputs
    always_comb begin
        active  = (state == MARCH) || (state == DESCEND);
        cleared = (state == CLEARED);
        landed  = (state == LANDED);
    end

    // Formation datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            origin_x      <= POS_W'(START_X);
            origin_y      <= POS_W'(START_Y);
            dir           <= DIR_RIGHT;
            step_cnt      <= '0;
            alive_matrix  <= '0;
            hit_ack       <= 1'b0;
            step_pulse    <= 1'b0;
            shooter_valid <= 1'b0;
            shooter_row   <= '0;
            shooter_col   <= '0;
        end else begin
            hit_ack       <= hit_kill;
            step_pulse    <= move;
            shooter_valid <= fire_hit;
            if (fire_hit) begin
                shooter_row <= pick_row;
                shooter_col <= pick_col;
            end
            if (start) begin
                origin_x     <= POS_W'(START_X);
                origin_y     <= POS_W'(START_Y);
                dir          <= DIR_RIGHT;
                step_cnt     <= '0;
                alive_matrix <= '1;
            end else begin
                if (hit_kill) alive_matrix <= alive_matrix & ~hit_sel;
                if (active && tick) step_cnt <= cnt_done ? '0 : step_cnt + 1'b1;
                if (move) begin
                    if (descend) begin
                        origin_y <= next_y;
                        dir      <= (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                    end else if (dir == DIR_RIGHT) begin
                        origin_x <= origin_x + POS_W'(STEP_X);
                    end else begin
                        origin_x <= origin_x - POS_W'(STEP_X);
                    end
                end
            end
        end
    end

endmodule

// File: doc/alien_formation_ctrl.md
Name: alien_formation_ctrl

Overview:
- Parametrised successor to the fixed-size formation. It holds the whole alien grid as one formation origin plus an alive bitmap.
- It marches the formation left and right on a step timer. At a screen edge it descends and reverses, and it speeds up as aliens die.
- It resolves hits from the collision unit and picks a shooter for the alien-fire unit.
- It sits between the game FSM (start, tick) and the renderer/collision logic. Per-alien position = origin + (col*SPACING_X, row*SPACING_Y).

Parameters:
- NUM_ROWS, 3, grid rows (row 0 = top)
- NUM_COLS, 5, grid columns
- POS_W, 16, coordinate width
- SPACING_X, 64, column pitch, pixels
- SPACING_Y, 32, row pitch, pixels
- START_X, 100, origin x on load
- START_Y, 50, origin y on load
- ALIEN_W, 32, sprite width
- ALIEN_H, 16, sprite height
- SCREEN_W, 640, right playfield limit (exclusive)
- LAND_Y, 400, y at which aliens have landed
- STEP_X, 8, horizontal step, pixels
- STEP_Y, 16, descend step, pixels
- MIN_PERIOD, 2, ticks per step with one alien left
- PERIOD_SCALE, 4, extra ticks per additional live alien

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  frame-rate enable, one-cycle pulse
- start  in  1  load a full formation and begin marching
- hit_valid  in  1  collision unit reports a hit
- hit_row  in  $clog2(NUM_ROWS)  row of the hit
- hit_col  in  $clog2(NUM_COLS)  column of the hit
- hit_ack  out  1  pulse: the hit killed a live alien
- fire_req  in  1  alien-fire unit requests a shooter
- fire_seed_col  in  $clog2(NUM_COLS)  preferred column (from external LFSR)
- shooter_valid  out  1  pulse: shooter chosen
- shooter_row  out  $clog2(NUM_ROWS)  chosen row
- shooter_col  out  $clog2(NUM_COLS)  chosen column
- origin_x  out  POS_W  formation origin x
- origin_y  out  POS_W  formation origin y
- alive_matrix  out  NUM_ROWS*NUM_COLS  [row][col] alive bits
- armed_matrix  out  NUM_ROWS*NUM_COLS  lowest live alien per column
- step_pulse  out  1  pulse on every move (drives sprite animation frame)
- cleared  out  1  level flag: all aliens dead
- landed  out  1  level flag: formation reached LAND_Y

Behaviour:
- Reset values: state IDLE, alive_matrix all 0, origin (START_X, START_Y), direction right. All pulses, cleared and landed are 0.
- States: IDLE, MARCH, DESCEND, CLEARED, LANDED.
- start in any state, the cycle after: alive all 1, origin = START, direction right, step counter 0, cleared/landed 0, state MARCH. start has priority over hit and tick in the same cycle.
- Step counter: counts ticks in MARCH/DESCEND. Period = MIN_PERIOD + (alive_count-1)*PERIOD_SCALE, recomputed every cycle. When counter+1 >= period on a tick, the counter clears and a move occurs; the period shrinking below the counter forces a move on the next tick.
- Edge detection: use the leftmost and rightmost live columns L and R.
  - Moving right: if origin_x + R*SPACING_X + ALIEN_W + STEP_X > SCREEN_W, the move is a descend.
  - Moving left: if origin_x + L*SPACING_X < STEP_X, the move is a descend.
  - Otherwise origin_x steps by ±STEP_X.
- Descend: origin_y += STEP_Y and direction flips, done as a single move. The state passes through DESCEND for exactly one cycle, then returns to MARCH.
- step_pulse is asserted in the cycle the origin changes.
- Landing: after any move, if origin_y + B*SPACING_Y + ALIEN_H >= LAND_Y (B = lowest live row), enter LANDED. landed=1 and movement stops.
- Hit: accepted only in MARCH/DESCEND, with hit_row/hit_col in range.
  - Target alive: clear the bit and hit_ack=1 one cycle after hit_valid.
  - Target dead or out of range: no ack, no change.
  - One hit per cycle.
- Clear: when the last alien dies, enter CLEARED the next cycle. cleared=1 and movement stops.
- Hit and move in the same cycle: both apply. Edge and period use the pre-hit matrix.
- armed_matrix: combinational from the registered alive_matrix. Bit set iff alive and no live alien in any lower row of the same column.
- Shooter: on fire_req in MARCH/DESCEND, scan columns from fire_seed_col upward, wrapping modulo NUM_COLS, and take the first column with an armed alien. The result is registered: shooter_valid pulses one cycle after fire_req. No armed alien (or other state) gives no pulse. fire_seed_col >= NUM_COLS is reduced modulo NUM_COLS.
- Arithmetic is unsigned POS_W bits. Parameters must keep origin within range, so no wrap occurs.
- Asynchronous reset mid-move returns everything to the reset values immediately.

Decomposition:
- Package alien_pkg: formation_state_t enum, direction_t enum, and clog2-derived width localparams shared with the renderer.
- One sub-module: alien_column_scan. It is combinational and produces L, R, B, alive_count, armed_matrix, and the first armed column from a seed. It is reused by the renderer/collision unit.

Test Plan:
- Reset, then start with defaults: origin (100,50), 15 alive; with tick every cycle, step_pulse every 58 ticks (2+14*4); origin_x 108 after first move.
- Run right until R edge: origin_x 100+8k with 100+8k+4*64+32+8 > 640 gives origin_y 66 and direction left on that move; the next move gives origin_x −8.
- Kill column 4 entirely via hits (ack each): R becomes 3, so the right turn occurs 64 px later; the double-hit on a dead alien gives no ack.
- Kill all but one alien: period 2; the final hit raises cleared next cycle, step_pulse stops, and start reloads all 15.
- fire_req with seed 2 while column 2 is empty and column 3 armed at row 2: shooter_valid one cycle later, row 2, col 3. All empty gives no pulse.
- Descend repeatedly until bottom row y + 16 >= 400: landed=1, origin frozen, hits ignored; start recovers to MARCH.
